// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave); rdata is valid in the cycle ready=1.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding request, single-entry skid buffer
// for a stalled IF/ID slot, and redirect handling that drops in-flight words.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic                  if_valid,
    output logic [31:0]           if_inst,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc4
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] opc4_q, opc4_d;

    logic        slot_free;
    logic [31:0] redir_pc;
    logic        unused_ok;

    assign slot_free = !valid_q || !stall_in;
    assign redir_pc  = {redirect_pc[31:2], 2'b00};
    assign unused_ok = ^redirect_pc[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        // A presented word is consumed whenever the slot is not stalled.
        valid_d     = valid_q && stall_in;
        inst_d      = inst_q;
        opc_d       = opc_q;
        opc4_d      = opc4_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_d        = redir_pc;
                    valid_d     = 1'b0;
                    skid_inst_d = '0;
                    skid_pc_d   = '0;
                    if (!imem.imem_ready) begin
                        state_d     = DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (slot_free) begin
                        valid_d = 1'b1;
                        inst_d  = imem.imem_rdata;
                        opc_d   = pc_q;
                        opc4_d  = pc_q + 32'd4;
                    end else begin
                        skid_inst_d = imem.imem_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d        = redir_pc;
                    valid_d     = 1'b0;
                    skid_inst_d = '0;
                    skid_pc_d   = '0;
                    state_d     = FETCH;
                end else if (!stall_in) begin
                    valid_d = 1'b1;
                    inst_d  = skid_inst_q;
                    opc_d   = skid_pc_q;
                    opc4_d  = skid_pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // The old request stays on the bus; a redirect here only retargets pc.
                if (redirect) begin
                    pc_d        = redir_pc;
                    valid_d     = 1'b0;
                    skid_inst_d = '0;
                    skid_pc_d   = '0;
                end else if (imem.imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            valid_q     <= 1'b0;
            inst_q      <= '0;
            opc_q       <= '0;
            opc4_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            opc4_q      <= opc4_d;
        end
    end

    assign imem.imem_req  = (state_q == FETCH) || (state_q == DISCARD);
    assign imem.imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;

    assign if_valid = valid_q;
    assign if_inst  = inst_q;
    assign if_pc    = opc_q;
    assign if_pc4   = opc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a request/queue level model of the fetch stream
// is checked every cycle, with directed sequences pinned by literal values.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc4;

    if_fetch_unit_if imem();

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Model: words delivered but not yet consumed (output slot then skid),
    // next address owed to the program stream, and a flag for an
    // in-flight request whose word must be thrown away.
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    bit          m_idle;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_fetch;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic bit m_req();
        return !m_idle && (q_pc.size() < 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_inst.delete();
        m_idle       = 1'b1;
        m_stale      = 1'b0;
        m_stale_addr = '0;
        m_fetch      = RESET_PC;
    endtask

    task automatic compare();
        bit exp_valid;
        bit exp_req;
        exp_valid = (q_pc.size() > 0);
        exp_req   = m_req();
        chk("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        chk("imem_req", {31'd0, imem.imem_req}, {31'd0, exp_req});
        if (exp_req && imem.imem_req)
            chk("imem_addr", imem.imem_addr, m_stale ? m_stale_addr : m_fetch);
        if (exp_valid && if_valid) begin
            chk("if_pc", if_pc, q_pc[0]);
            chk("if_inst", if_inst, q_inst[0]);
            chk("if_pc4", if_pc4, q_pc[0] + 32'd4);
        end
    endtask

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit req;
        stall_in         = st;
        redirect         = rd;
        redirect_pc      = rpc;
        imem.imem_ready  = rdy;
        imem.imem_rdata  = mem_word(imem.imem_addr);
        req = m_req();
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            if (q_pc.size() > 0 && !st) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (rd) begin
                q_pc.delete();
                q_inst.delete();
                if (req && !rdy && !m_stale) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_fetch;
                end
                m_fetch = {rpc[31:2], 2'b00};
            end else if (req && rdy) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    q_pc.push_back(m_fetch);
                    q_inst.push_back(mem_word(m_fetch));
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem.imem_req}, 32'd0);
        chk({tag, "_inst"}, if_inst, 32'd0);
        chk({tag, "_pc"}, if_pc, 32'd0);
        chk({tag, "_pc4"}, if_pc4, 32'd0);
    endtask

    // Assert reset between edges, check outputs clear at once, release on a falling edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs({tag, "_hold"});
        rst = 1'b1;
        model_reset();
        #1;
        compare();
    endtask

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_rdata = '0;
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare();

        // Back-to-back fetch with ready tied high
        step(0, 0, 0, 1);
        chk("first_addr", imem.imem_addr, 32'h0);
        chk("first_req", {31'd0, imem.imem_req}, 32'd1);
        step(0, 0, 0, 1);
        chk("b2b_addr4", imem.imem_addr, 32'h4);
        chk("b2b_pc0", if_pc, 32'h0);
        step(0, 0, 0, 1);
        chk("b2b_addr8", imem.imem_addr, 32'h8);
        chk("b2b_pc4", if_pc, 32'h4);
        step(0, 0, 0, 1);
        chk("b2b_pc8", if_pc, 32'h8);
        chk("b2b_valid", {31'd0, if_valid}, 32'd1);
        step(0, 0, 0, 1);

        // Wait states at 0x10
        for (int unsigned k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk("wait_addr", imem.imem_addr, 32'h10);
        end
        step(0, 0, 0, 1);
        chk("wait_pc", if_pc, 32'h10);
        chk("wait_inst", if_inst, mem_word(32'h10));

        // Stall with a handshake: skid then release
        step(1, 0, 0, 1);
        chk("hold_req", {31'd0, imem.imem_req}, 32'd0);
        chk("hold_pc", if_pc, 32'h10);
        step(1, 0, 0, 1);
        chk("hold2_pc", if_pc, 32'h10);
        step(0, 0, 0, 0);
        chk("skid_pc", if_pc, 32'h14);
        chk("skid_addr", imem.imem_addr, 32'h18);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("pre_redir_pc", if_pc, 32'h1C);

        // Redirect to 0x103 while 0x20 is pending
        step(0, 0, 0, 0);
        step(0, 1, 32'h103, 0);
        chk("disc_addr", imem.imem_addr, 32'h20);
        step(0, 0, 0, 1);
        chk("disc_valid", {31'd0, if_valid}, 32'd0);
        chk("disc_next", imem.imem_addr, 32'h100);
        step(0, 0, 0, 1);
        chk("redir_pc", if_pc, 32'h100);

        // Redirect coincident with ready
        step(0, 1, 32'h200, 1);
        chk("rr_valid", {31'd0, if_valid}, 32'd0);
        chk("rr_addr", imem.imem_addr, 32'h200);

        // PC wrap-around
        step(0, 1, 32'hFFFF_FFF9, 1);
        chk("wrap_addr0", imem.imem_addr, 32'hFFFF_FFF8);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_addr", imem.imem_addr, 32'h0);
        chk("wrap_pc4", if_pc4, 32'h0);

        // Reset during a wait state
        step(0, 0, 0, 0);
        async_reset("midrst");
        step(0, 0, 0, 1);
        chk("restart_addr", imem.imem_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
                 $urandom, $urandom_range(0, 99) < 60);
            if (i == 1500) async_reset("rndrst");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
